// File: rtl/credit_link_arbiter.sv
// credit_link_arbiter
//   Round-robin arbiter sharing one credit-flow-controlled outbound link
//   among N_REQ requesters. It owns the link credit counter. It grants at
//   most one word per cycle, and only while a credit is available.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   en            arbitration enable (0 = no new grants)
//   req_valid     per-requester word available
//   req_data      packed per-requester words, requester i at [i*DATA_W +: DATA_W]
//   req_ready     one-hot grant; the granted word is consumed this cycle
//   credit_ret    one-cycle pulse returning one credit
//   link_valid    registered: link_data valid this cycle
//   link_data     registered payload
//   link_src      index of the requester that supplied link_data
//   credit_cnt    current credit count
//   err_overflow  sticky: credit returned while the count was at MAX_CREDITS
module credit_link_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MAX_CREDITS  = 4,
  parameter int unsigned INIT_CREDITS = 1,
  localparam int unsigned SRC_W       = $clog2(N_REQ),
  localparam int unsigned CNT_W       = $clog2(MAX_CREDITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      credit_ret,
  output logic                      link_valid,
  output logic [DATA_W-1:0]         link_data,
  output logic [SRC_W-1:0]          link_src,
  output logic [CNT_W-1:0]          credit_cnt,
  output logic                      err_overflow
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CREDITS);
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_CREDITS);
  localparam logic [SRC_W-1:0] LAST   = SRC_W'(N_REQ - 1);

  logic [SRC_W-1:0]  ptr_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [SRC_W-1:0]  src_q;
  logic [CNT_W-1:0]  credit_q, credit_d;
  logic              err_q, err_d;

  logic              win_found;
  logic [SRC_W-1:0]  win_idx;
  logic              grant;

  // Winner: first valid requester searching upward from ptr_q+1, wrapping.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_valid[cand[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // Grant depends on the registered count only, so a same-cycle credit
  // return never enables a send; rst_n gates req_ready during reset.
  assign grant = rst_n && en && (credit_q != '0) && win_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    unique case ({grant, credit_ret})
      2'b10: credit_d = credit_q - CNT_W'(1);
      2'b01: begin
        if (credit_q == MAX_C) err_d = 1'b1;
        else                   credit_d = credit_q + CNT_W'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q    <= LAST;
      valid_q  <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
      credit_q <= INIT_C;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= grant;
      credit_q <= credit_d;
      err_q    <= err_d;
      if (grant) begin
        data_q <= req_data[win_idx*DATA_W +: DATA_W];
        src_q  <= win_idx;
        ptr_q  <= win_idx;
      end
    end
  end

  assign link_valid   = valid_q;
  assign link_data    = data_q;
  assign link_src     = src_q;
  assign credit_cnt   = credit_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_credit_link_arbiter.sv
module tb_credit_link_arbiter;
  localparam int unsigned N      = 4;
  localparam int unsigned DW     = 64;
  localparam int unsigned MAXC   = 4;
  localparam int unsigned INITC  = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            credit_ret;
  logic            link_valid;
  logic [DW-1:0]   link_data;
  logic [1:0]      link_src;
  logic [2:0]      credit_cnt;
  logic            err_overflow;

  logic [DW-1:0]   words [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = words[i];
  end

  credit_link_arbiter #(
    .N_REQ(N), .DATA_W(DW), .MAX_CREDITS(MAXC), .INIT_CREDITS(INITC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .credit_ret(credit_ret),
    .link_valid(link_valid), .link_data(link_data), .link_src(link_src),
    .credit_cnt(credit_cnt), .err_overflow(err_overflow)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer credit count, last-winner pointer, expected link outputs.
  bit          m_known = 0;
  int          m_cnt, m_ptr, m_src;
  bit          m_err, m_lv;
  logic [DW-1:0] m_data;

  always @(negedge clk) begin
    int win;
    logic [N-1:0] exp_rdy;
    win = -1;
    exp_rdy = '0;
    if (rst_n === 1'b1 && en && m_known && m_cnt > 0)
      for (int k = 1; k <= N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (win >= 0) exp_rdy[win] = 1'b1;
    if (m_known || rst_n === 1'b0) chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    if (m_known) begin
      chk("link_valid", DW'(link_valid), DW'(m_lv));
      chk("link_data", link_data, m_data);
      chk("link_src", DW'(link_src), DW'(m_src));
      chk("credit_cnt", DW'(credit_cnt), DW'(m_cnt));
      chk("err_overflow", DW'(err_overflow), DW'(m_err));
    end
    if (rst_n === 1'b0) begin
      m_known = 1; m_cnt = INITC; m_ptr = N - 1; m_src = 0;
      m_err = 0; m_lv = 0; m_data = '0;
    end else if (m_known) begin
      m_lv = (win >= 0);
      if (win >= 0) begin
        m_data = words[win]; m_src = win; m_ptr = win;
        if (!credit_ret) m_cnt = m_cnt - 1;
      end else if (credit_ret) begin
        if (m_cnt == MAXC) m_err = 1;
        else m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req_valid = '0; credit_ret = 1'b0;
    for (int i = 0; i < N; i++) words[i] = {32'h1000_0000 + 32'(i), 32'h0000_00a0 + 32'(i)};
    words[0] = 64'hdeedabba_cafeface;
    steps(2);
    rst_n = 1'b1;

    // Single word with one initial credit
    en = 1'b1; req_valid = 4'b0001;
    #1 chk("t1_ready", DW'(req_ready), 64'h1);
    step();
    chk("t1_lv", DW'(link_valid), 64'h1);
    chk("t1_data", link_data, 64'hdeedabba_cafeface);
    chk("t1_src", DW'(link_src), 64'h0);
    chk("t1_cnt", DW'(credit_cnt), 64'h0);
    #1 chk("t1_noready", DW'(req_ready), 64'h0);
    step();
    chk("t1_lv0", DW'(link_valid), 64'h0);

    // Credit return does not grant in its own cycle
    credit_ret = 1'b1;
    #1 chk("t2_ready_pulse", DW'(req_ready), 64'h0);
    step();
    credit_ret = 1'b0;
    chk("t2_cnt1", DW'(credit_cnt), 64'h1);
    #1 chk("t2_ready", DW'(req_ready), 64'h1);
    step();
    chk("t2_cnt0", DW'(credit_cnt), 64'h0);
    chk("t2_lv", DW'(link_valid), 64'h1);

    // Fresh reset, fill to MAX, all requesting: order 0,1,2,3
    req_valid = '0; rst_n = 1'b0; step(); rst_n = 1'b1;
    credit_ret = 1'b1; steps(3); credit_ret = 1'b0;
    chk("t3_full", DW'(credit_cnt), 64'h4);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_src", DW'(link_src), DW'(i));
      chk("t3_cnt", DW'(credit_cnt), DW'(3 - i));
    end
    #1 chk("t3_noready", DW'(req_ready), 64'h0);
    step();
    chk("t3_lv0", DW'(link_valid), 64'h0);

    // Back-to-back with a return on every grant: count stays at 2
    req_valid = '0; credit_ret = 1'b1; steps(2);
    chk("t4_cnt2", DW'(credit_cnt), 64'h2);
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_lv", DW'(link_valid), 64'h1);
      chk("t4_cnt", DW'(credit_cnt), 64'h2);
    end

    // Overflow is sticky until reset
    req_valid = '0; steps(2);
    chk("t5_cnt4", DW'(credit_cnt), 64'h4);
    chk("t5_noerr", DW'(err_overflow), 64'h0);
    step();
    credit_ret = 1'b0;
    chk("t5_err", DW'(err_overflow), 64'h1);
    chk("t5_sat", DW'(credit_cnt), 64'h4);
    step();
    chk("t5_sticky", DW'(err_overflow), 64'h1);
    rst_n = 1'b0; req_valid = 4'b1111;
    #1 chk("t5_rst_ready", DW'(req_ready), 64'h0);
    step();
    chk("t5_clr", DW'(err_overflow), 64'h0);
    chk("t5_init", DW'(credit_cnt), 64'h1);
    chk("t5_lv0", DW'(link_valid), 64'h0);
    req_valid = '0; rst_n = 1'b1;

    // Fairness: 1,3 then 0 joins -> 0,1,3; en=0 holds the pointer
    credit_ret = 1'b1; steps(3);
    req_valid = 4'b1010;
    #1 chk("t6_r1", DW'(req_ready), 64'h2);
    step(); chk("t6_s1", DW'(link_src), 64'h1);
    #1 chk("t6_r3", DW'(req_ready), 64'h8);
    step(); chk("t6_s3", DW'(link_src), 64'h3);
    req_valid = 4'b1011;
    #1 chk("t6_r0", DW'(req_ready), 64'h1);
    step(); chk("t6_s0", DW'(link_src), 64'h0);
    step(); chk("t6_s1b", DW'(link_src), 64'h1);
    step(); chk("t6_s3b", DW'(link_src), 64'h3);
    chk("t6_cnt", DW'(credit_cnt), 64'h4);
    en = 1'b0; credit_ret = 1'b0;
    #1 chk("t6_en0", DW'(req_ready), 64'h0);
    step();
    chk("t6_lv0", DW'(link_valid), 64'h0);
    en = 1'b1;
    #1 chk("t6_ptr_held", DW'(req_ready), 64'h1);
    step();
    chk("t6_s0b", DW'(link_src), 64'h0);
    req_valid = '0;
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
